// File: rtl/spi_slave_sync.sv
// SPI responder running entirely in the CLK domain: SCK/SS/MOSI are oversampled,
// edges classified by CKP/CPH, and a WIDTH-bit frame is shifted in and out.
module spi_slave_sync #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             CKP,
   input  logic             CPH,
   input  logic             SCK,
   input  logic             SS,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_load,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sck_prev;
   logic                   ss_prev;
   logic [WIDTH-1:0]       shift_reg;
   logic [WIDTH-1:0]       pend_buf;
   logic                   pending;
   logic [CNT_W-1:0]       bit_cnt;

   logic                   sck_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   ss_fall;
   logic                   ss_rise;
   logic                   lead_edge;
   logic                   trail_edge;
   logic                   sample_edge;
   logic                   drive_edge;
   logic [WIDTH-1:0]       shift_next;

   assign sck_s       = sck_sync[SYNC_STAGES-1];
   assign ss_s        = ss_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sck_rise    = ~sck_prev & sck_s;
   assign sck_fall    = sck_prev & ~sck_s;
   assign ss_fall     = ss_prev & ~ss_s;
   assign ss_rise     = ~ss_prev & ss_s;
   assign lead_edge   = CKP ? sck_fall : sck_rise;
   assign trail_edge  = CKP ? sck_rise : sck_fall;
   assign sample_edge = CPH ? trail_edge : lead_edge;
   assign drive_edge  = CPH ? lead_edge : trail_edge;
   assign shift_next  = {shift_reg[WIDTH-2:0], mosi_s};

   // Synchronizers reset to the idle bus levels so no edge is seen on release.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         sck_sync  <= {SYNC_STAGES{CKP}};
         ss_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= CKP;
         ss_prev   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sck_prev  <= sck_s;
         ss_prev   <= ss_s;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state     <= IDLE;
         MISO      <= 1'b0;
         tx_ready  <= 1'b1;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         shift_reg <= '0;
         pend_buf  <= '0;
         pending   <= 1'b0;
         bit_cnt   <= '0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state    <= SHIFT;
                  busy     <= 1'b1;
                  tx_ready <= 1'b0;
                  bit_cnt  <= '0;
                  pending  <= 1'b0;
                  // A load coinciding with SS falling beats any older pending word.
                  if (tx_load) begin
                     shift_reg <= tx_data;
                     MISO      <= tx_data[WIDTH-1];
                  end else if (pending) begin
                     shift_reg <= pend_buf;
                     MISO      <= pend_buf[WIDTH-1];
                  end else begin
                     MISO <= shift_reg[WIDTH-1];
                  end
               end else if (tx_load) begin
                  pend_buf <= tx_data;
                  pending  <= 1'b1;
               end
            end
            SHIFT: begin
               if (ss_rise) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  tx_ready  <= 1'b1;
                  MISO      <= 1'b0;
                  frame_err <= (bit_cnt != '0);
                  bit_cnt   <= '0;
               end else if (sample_edge) begin
                  shift_reg <= shift_next;
                  if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                     rx_data  <= shift_next;
                     rx_valid <= 1'b1;
                     bit_cnt  <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else if (drive_edge) begin
                  MISO <= shift_reg[WIDTH-1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Self-checking bench for spi_slave_sync: a bit-banged SPI master against a
// delay-line model of the responder (MISO stream = held word followed by MOSI stream).
module tb_spi_slave_sync;

   localparam int HALF = 8;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        CKP;
   logic        CPH;
   logic        SCK;
   logic        SS;
   logic        MOSI;
   logic        MISO;
   logic [15:0] tx_data;
   logic        tx_load;
   logic        tx_ready;
   logic [15:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int rxValidSeen = 0;
   int frameErrSeen = 0;

   logic [15:0] mdlContent = 16'h0;
   logic [15:0] mdlPend = 16'h0;
   logic        mdlPendValid = 1'b0;
   logic [15:0] mdlRxData = 16'h0;

   spi_slave_sync #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .CLK(CLK), .Reset(Reset), .CKP(CKP), .CPH(CPH), .SCK(SCK), .SS(SS),
      .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .tx_load(tx_load),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (rx_valid === 1'b1) rxValidSeen++;
      if (frame_err === 1'b1) frameErrSeen++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic checkIdleOutputs(input string phase);
      checkOutput({phase, "_miso"}, 32'(MISO), 32'd0);
      checkOutput({phase, "_busy"}, 32'(busy), 32'd0);
      checkOutput({phase, "_tx_ready"}, 32'(tx_ready), 32'd1);
      checkOutput({phase, "_rx_data"}, 32'(rx_data), 32'(mdlRxData));
   endtask

   task automatic setMode(input logic ckp, input logic cph);
      @(negedge CLK);
      CKP = ckp;
      CPH = cph;
      SCK = ckp;
      waitCycles(HALF);
   endtask

   task automatic loadWord(input logic [15:0] w);
      @(negedge CLK);
      checkOutput("tx_ready_idle", 32'(tx_ready), 32'd1);
      tx_data = w;
      tx_load = 1'b1;
      @(negedge CLK);
      tx_load = 1'b0;
      mdlPend = w;
      mdlPendValid = 1'b1;
   endtask

   // Clocks nbits bits with SS already low; MOSI is sent from bit nbits-1 down.
   task automatic clockBits(input logic [31:0] mosiWord, input int nbits, input bit loadBusy,
                            input logic [15:0] busyWord, output logic [31:0] misoWord);
      int bitIdx;
      misoWord = 32'h0;
      for (int i = 0; i < nbits; i++) begin
         bitIdx = nbits - 1 - i;
         if (!CPH) begin
            misoWord = {misoWord[30:0], MISO};
            SCK = ~CKP;
            waitCycles(HALF);
            SCK = CKP;
            if (bitIdx > 0) MOSI = mosiWord[bitIdx-1];
            waitCycles(HALF);
         end else begin
            SCK = ~CKP;
            MOSI = mosiWord[bitIdx];
            waitCycles(HALF);
            misoWord = {misoWord[30:0], MISO};
            SCK = CKP;
            waitCycles(HALF);
         end
         if (i == 2) begin
            checkOutput("busy_mid", 32'(busy), 32'd1);
            checkOutput("tx_ready_mid", 32'(tx_ready), 32'd0);
            if (loadBusy) begin
               tx_data = busyWord;
               tx_load = 1'b1;
               waitCycles(1);
               tx_load = 1'b0;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [31:0] mosiWord, input int nbits, input bit loadAtFall,
                                input logic [15:0] fallWord, input bit loadBusy, input logic [15:0] busyWord);
      logic [31:0] misoWord;
      logic [31:0] aligned;
      logic [31:0] expMiso;
      logic [47:0] stream;
      logic [15:0] startContent;
      int          fullFrames;
      if (loadAtFall)        startContent = fallWord;
      else if (mdlPendValid) startContent = mdlPend;
      else                   startContent = mdlContent;
      mdlPendValid = 1'b0;
      aligned = mosiWord << (32 - nbits);
      stream = {startContent, aligned};
      expMiso = stream[47:16] >> (32 - nbits);
      fullFrames = nbits / 16;
      if (fullFrames > 0) mdlRxData = aligned[31-16*(fullFrames-1) -: 16];

      rxValidSeen = 0;
      frameErrSeen = 0;
      @(negedge CLK);
      SS = 1'b0;
      if (!CPH) MOSI = mosiWord[nbits-1];
      if (loadAtFall) begin
         waitCycles(2);
         tx_data = fallWord;
         tx_load = 1'b1;
         waitCycles(1);
         tx_load = 1'b0;
         waitCycles(HALF - 3);
      end else begin
         waitCycles(HALF);
      end
      clockBits(mosiWord, nbits, loadBusy, busyWord, misoWord);
      SS = 1'b1;
      MOSI = 1'b0;
      waitCycles(HALF);

      checkOutput("miso_stream", misoWord, expMiso);
      checkOutput("rx_valid_pulses", 32'(rxValidSeen), 32'(fullFrames));
      checkOutput("frame_err_pulses", 32'(frameErrSeen), (nbits % 16 != 0) ? 32'd1 : 32'd0);
      checkIdleOutputs("end");
      mdlContent = stream[47-nbits -: 16];
   endtask

   task automatic resetMidFrame(input logic [31:0] mosiWord);
      logic [31:0] dummy;
      rxValidSeen = 0;
      frameErrSeen = 0;
      @(negedge CLK);
      SS = 1'b0;
      if (!CPH) MOSI = mosiWord[15];
      waitCycles(HALF);
      clockBits(mosiWord, 9, 1'b0, 16'h0, dummy);
      Reset = 1'b1;
      waitCycles(1);
      mdlContent = 16'h0;
      mdlPend = 16'h0;
      mdlPendValid = 1'b0;
      mdlRxData = 16'h0;
      checkIdleOutputs("rst");
      checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      SS = 1'b1;
      SCK = CKP;
      MOSI = 1'b0;
      waitCycles(4);
      Reset = 1'b0;
      waitCycles(HALF);
      checkOutput("rst_pulses", 32'(rxValidSeen + frameErrSeen), 32'd0);
   endtask

   initial begin
      logic [31:0] rnd;
      int          nb;
      Reset = 1'b1;
      CKP = 1'b0;
      CPH = 1'b0;
      SCK = 1'b0;
      SS = 1'b1;
      MOSI = 1'b0;
      tx_data = 16'h0;
      tx_load = 1'b0;
      waitCycles(4);
      checkIdleOutputs("reset");
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      Reset = 1'b0;
      waitCycles(4);

      setMode(1'b0, 1'b0);
      loadWord(16'hA5C3);
      applyStimulus(32'h3C5A, 16, 1'b0, 16'h0, 1'b0, 16'h0);
      for (int m = 1; m < 4; m++) begin
         setMode(m[1], m[0]);
         loadWord(16'h8001);
         applyStimulus(32'h7FFE, 16, 1'b0, 16'h0, 1'b0, 16'h0);
      end

      // Abort after 7 bits, then a clean frame carrying the partial contents.
      applyStimulus(32'($urandom_range(0, 127)), 7, 1'b0, 16'h0, 1'b0, 16'h0);
      applyStimulus(32'($urandom_range(0, 65535)), 16, 1'b0, 16'h0, 1'b0, 16'h0);

      applyStimulus(32'($urandom_range(0, 65535)), 16, 1'b0, 16'h0, 1'b1, 16'hBEEF);
      loadWord(16'hBEEF);
      applyStimulus(32'($urandom_range(0, 65535)), 16, 1'b0, 16'h0, 1'b0, 16'h0);

      loadWord(16'h1234);
      applyStimulus(32'($urandom_range(0, 65535)), 16, 1'b1, 16'h5678, 1'b0, 16'h0);
      applyStimulus($urandom, 32, 1'b0, 16'h0, 1'b0, 16'h0);

      setMode(1'b0, 1'b0);
      resetMidFrame($urandom);
      applyStimulus(32'($urandom_range(0, 65535)), 16, 1'b0, 16'h0, 1'b0, 16'h0);

      for (int r = 0; r < 20; r++) begin
         setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) loadWord(16'($urandom));
         if ($urandom_range(0, 3) == 0) loadWord(16'($urandom));
         nb = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(1, 32));
         rnd = $urandom;
         applyStimulus(rnd, nb, $urandom_range(0, 7) == 0, 16'($urandom),
                       $urandom_range(0, 3) == 0, 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
